// File: rtl/falafel_lsu.sv
// falafel_lsu: responder end of the allocator header channel. Executes free-list
// commands (LOCK/UNLOCK/LOAD/SET_INSERT_ADDR/INSERT/DELETE) over a single-outstanding
// 64-bit word memory port.
// Optional build macro FALAFEL_LSU_ALIGN_CHECK_EN: rejects header addresses that are
// not 8-byte aligned with err_o and a zeroed response instead of touching memory.

package falafel_lsu_pkg;
    // Marks "no insert position chosen yet"; link writes then land on the head slot.
    localparam logic [63:0] EMPTY_KEY              = 64'h0;
    localparam logic [63:0] BLOCK_NEXT_ADDR_OFFSET = 64'd8;

    typedef enum logic [2:0] {
        OP_LOCK            = 3'd0,
        OP_UNLOCK          = 3'd1,
        OP_LOAD            = 3'd2,
        OP_SET_INSERT_ADDR = 3'd3,
        OP_INSERT          = 3'd4,
        OP_DELETE          = 3'd5
    } lsu_op_e;

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] size;
        logic [63:0] next_addr;
    } header_t;

    typedef struct packed {
        logic    val;
        lsu_op_e op;
        header_t header;
    } header_data_req_t;

    typedef struct packed {
        logic    val;
        header_t header;
    } header_data_rsp_t;
endpackage

module falafel_lsu
    import falafel_lsu_pkg::*;
#(
    parameter logic [63:0] LOCK_ADDR     = 64'h0,
    parameter int unsigned LOCK_SPIN_MAX = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  header_data_req_t req_i,
    output logic             ready_o,
    output header_data_rsp_t rsp_o,
    output logic             err_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [63:0]      mem_addr_o,
    output logic [63:0]      mem_wdata_o,
    input  logic             mem_gnt_i,
    input  logic             mem_rvalid_i,
    input  logic [63:0]      mem_rdata_i
);

    typedef enum logic [3:0] {
        IDLE, LK_RD, LK_WR, RD_SIZE, RD_NEXT, WR_SIZE, WR_NEXT, WR_LINK, RESP
    } state_e;

    state_e      state_q, state_d;
    lsu_op_e     op_q, op_d;
    header_t     hdr_q, hdr_d;          // latched command header, doubles as response header
    logic [63:0] prev_q, prev_d;
    logic [31:0] spin_q, spin_d;
    logic        gnt_seen_q, gnt_seen_d; // current access granted, read still waiting for data
    logic        mem_we_q, mem_we_d;
    logic [63:0] mem_addr_q, mem_addr_d;
    logic [63:0] mem_wdata_q, mem_wdata_d;
`ifdef FALAFEL_LSU_ALIGN_CHECK_EN
    logic        err_q, err_d;
`endif

    logic in_access, acc_gnt, acc_done, launch, misaligned;

    assign in_access = state_q inside {LK_RD, LK_WR, RD_SIZE, RD_NEXT, WR_SIZE, WR_NEXT, WR_LINK};
    assign mem_req_o = in_access && !gnt_seen_q;
    assign acc_gnt   = mem_req_o && mem_gnt_i;
    // Read data may come back in the grant cycle or any later one.
    assign acc_done  = mem_we_q ? acc_gnt : ((gnt_seen_q || acc_gnt) && mem_rvalid_i);

`ifdef FALAFEL_LSU_ALIGN_CHECK_EN
    assign misaligned = (req_i.op inside {OP_LOAD, OP_INSERT, OP_DELETE, OP_SET_INSERT_ADDR})
                        && (req_i.header.addr[2:0] != 3'd0);
    assign err_o      = (state_q == RESP) && err_q;
`else
    assign misaligned = 1'b0;
    assign err_o      = 1'b0;
`endif

    assign ready_o     = (state_q == IDLE);
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

    // Response is driven only during RESP and is all-zero otherwise.
    always_comb begin
        rsp_o = '0;
        if (state_q == RESP) begin
            rsp_o.val    = 1'b1;
            rsp_o.header = hdr_q;
        end
    end

    // Next-state logic; entering an access state loads the memory request registers.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves a latch behind.
        state_d     = state_q;
        op_d        = op_q;
        hdr_d       = hdr_q;
        prev_d      = prev_q;
        spin_d      = spin_q;
        gnt_seen_d  = gnt_seen_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        launch      = 1'b0;
`ifdef FALAFEL_LSU_ALIGN_CHECK_EN
        err_d       = err_q;
`endif
        if (acc_gnt) gnt_seen_d = 1'b1;

        unique case (state_q)
            IDLE: if (req_i.val) begin
                op_d  = req_i.op;
                hdr_d = req_i.header;
`ifdef FALAFEL_LSU_ALIGN_CHECK_EN
                err_d = misaligned;
`endif
                if (misaligned) begin
                    hdr_d.size      = '0;
                    hdr_d.next_addr = EMPTY_KEY;
                    state_d         = RESP;
                end else begin
                    launch = 1'b1;
                    case (req_i.op)
                        OP_LOCK:   state_d = LK_RD;
                        OP_UNLOCK: state_d = LK_WR;
                        OP_LOAD:   state_d = RD_SIZE;
                        OP_INSERT: state_d = WR_SIZE;
                        OP_DELETE: state_d = WR_LINK;
                        OP_SET_INSERT_ADDR: begin
                            prev_d  = req_i.header.addr;
                            launch  = 1'b0;
                            state_d = RESP;
                        end
                        default: begin
                            launch  = 1'b0;
                            state_d = RESP;
                        end
                    endcase
                end
            end
            LK_RD: if (acc_done) begin
                if (mem_rdata_i != 64'd0) begin
                    // Lock held: retry, giving up after LOCK_SPIN_MAX failed reads (0 = never).
                    if ((LOCK_SPIN_MAX != 0) && (spin_q + 32'd1 == 32'(LOCK_SPIN_MAX))) begin
                        spin_d  = '0;
                        state_d = IDLE;
                    end else begin
                        spin_d = spin_q + 32'd1;
                        launch = 1'b1;
                    end
                end else begin
                    spin_d  = '0;
                    state_d = LK_WR;
                    launch  = 1'b1;
                end
            end
            LK_WR:   if (acc_done) state_d = RESP;
            RD_SIZE: if (acc_done) begin
                hdr_d.size = mem_rdata_i;
                state_d    = RD_NEXT;
                launch     = 1'b1;
            end
            RD_NEXT: if (acc_done) begin
                hdr_d.next_addr = mem_rdata_i;
                state_d         = RESP;
            end
            WR_SIZE: if (acc_done) begin
                state_d = WR_NEXT;
                launch  = 1'b1;
            end
            WR_NEXT: if (acc_done) begin
                state_d = WR_LINK;
                launch  = 1'b1;
            end
            WR_LINK: if (acc_done) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (launch) begin
            gnt_seen_d = 1'b0;
            case (state_d)
                LK_RD: begin
                    mem_we_d   = 1'b0;
                    mem_addr_d = LOCK_ADDR;
                end
                LK_WR: begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = LOCK_ADDR;
                    mem_wdata_d = (op_d == OP_LOCK) ? 64'd1 : 64'd0;
                end
                RD_SIZE: begin
                    mem_we_d   = 1'b0;
                    mem_addr_d = hdr_d.addr;
                end
                RD_NEXT: begin
                    mem_we_d   = 1'b0;
                    mem_addr_d = hdr_d.addr + BLOCK_NEXT_ADDR_OFFSET;
                end
                WR_SIZE: begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = hdr_d.addr;
                    mem_wdata_d = hdr_d.size;
                end
                WR_NEXT: begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = hdr_d.addr + BLOCK_NEXT_ADDR_OFFSET;
                    mem_wdata_d = hdr_d.next_addr;
                end
                WR_LINK: begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = prev_d + BLOCK_NEXT_ADDR_OFFSET;
                    mem_wdata_d = (op_d == OP_INSERT) ? hdr_d.addr : hdr_d.next_addr;
                end
                default: ;
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_ni) begin
            state_q     <= IDLE;
            op_q        <= OP_LOCK;
            hdr_q       <= '0;
            prev_q      <= EMPTY_KEY;
            spin_q      <= '0;
            gnt_seen_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            hdr_q       <= hdr_d;
            prev_q      <= prev_d;
            spin_q      <= spin_d;
            gnt_seen_q  <= gnt_seen_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

`ifdef FALAFEL_LSU_ALIGN_CHECK_EN
    // Error flag travels with the command until its response.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) err_q <= 1'b0;
        else         err_q <= err_d;
    end
`endif

endmodule
